// File: rtl/spgd_update_if.sv
// rtl/spgd_update_if.sv - control/measurement bus of the SPGD update engine
interface spgd_update_if #(
    parameter int FP_WIDTH = 64
) ();
    logic                START;
    logic                ABORT;
    logic                LOAD;
    logic [FP_WIDTH-1:0] U_INIT;
    logic [FP_WIDTH-1:0] PERT;
    logic [FP_WIDTH-1:0] GAIN;
    logic [FP_WIDTH-1:0] METRIC;
    logic                METRIC_VALID;
    logic [FP_WIDTH-1:0] U_OUT;
    logic                MEAS_REQ;
    logic                BUSY;
    logic                DONE;

    modport master (
        output START, ABORT, LOAD, U_INIT, PERT, GAIN, METRIC, METRIC_VALID,
        input  U_OUT, MEAS_REQ, BUSY, DONE
    );

    modport slave (
        input  START, ABORT, LOAD, U_INIT, PERT, GAIN, METRIC, METRIC_VALID,
        output U_OUT, MEAS_REQ, BUSY, DONE
    );
endinterface

// File: rtl/spgd_update.sv
// rtl/spgd_update.sv - SPGD control-update engine: +delta/-delta probe, metric capture, gradient step
module spgd_update #(
    parameter int FP_WIDTH  = 64,
    parameter int INT_WIDTH = 16
) (
    input  logic          clk,
    input  logic          rst,
    spgd_update_if.slave  bus
);
    localparam int PW = 2 * FP_WIDTH;

    typedef logic signed [FP_WIDTH-1:0] fp_t;
    typedef enum logic [2:0] {
        S_IDLE, S_PLUS, S_WAIT_P, S_MINUS, S_WAIT_M, S_MUL_G, S_MUL_P, S_UPD
    } state_t;

    localparam fp_t FP_MAX = {1'b0, {(FP_WIDTH-1){1'b1}}};
    localparam fp_t FP_MIN = {1'b1, {(FP_WIDTH-1){1'b0}}};

    // One guard bit is enough to detect overflow of a single add/sub.
    function automatic fp_t sat_sum(input fp_t a, input fp_t b, input logic sub);
        logic signed [FP_WIDTH:0] s;
        s = sub ? ((FP_WIDTH+1)'(a) - (FP_WIDTH+1)'(b))
                : ((FP_WIDTH+1)'(a) + (FP_WIDTH+1)'(b));
        if (s[FP_WIDTH] != s[FP_WIDTH-1])
            return s[FP_WIDTH] ? FP_MIN : FP_MAX;
        return s[FP_WIDTH-1:0];
    endfunction

    // Rescale a full product back to the operand format; the dropped integer
    // bits must be pure sign extension of the kept MSB or the result clamps.
    function automatic fp_t trim(input logic signed [PW-1:0] p);
        logic [INT_WIDTH:0] top;
        top = p[PW-1 -: INT_WIDTH+1];
        if ((&top) || (~|top))
            return p[PW-1-INT_WIDTH -: FP_WIDTH];
        return p[PW-1] ? FP_MIN : FP_MAX;
    endfunction

    state_t state, state_n;
    fp_t    u, u_n, u_out, u_out_n, delta, delta_n, gain, gain_n;
    fp_t    jp, jp_n, jm, jm_n, gd, gd_n, step, step_n;
    logic   meas_req, meas_req_n, done, done_n;
    logic signed [PW-1:0] prod_g, prod_s;

    assign prod_g = PW'(gain) * PW'(sat_sum(jp, jm, 1'b1));
    assign prod_s = PW'(gd) * PW'(delta);

    assign bus.U_OUT    = u_out;
    assign bus.MEAS_REQ = meas_req;
    assign bus.BUSY     = (state != S_IDLE);
    assign bus.DONE     = done;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            u        <= '0;
            u_out    <= '0;
            delta    <= '0;
            gain     <= '0;
            jp       <= '0;
            jm       <= '0;
            gd       <= '0;
            step     <= '0;
            meas_req <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            u        <= u_n;
            u_out    <= u_out_n;
            delta    <= delta_n;
            gain     <= gain_n;
            jp       <= jp_n;
            jm       <= jm_n;
            gd       <= gd_n;
            step     <= step_n;
            meas_req <= meas_req_n;
            done     <= done_n;
        end
    end

    always_comb begin
        state_n    = state;
        u_n        = u;
        u_out_n    = u_out;
        delta_n    = delta;
        gain_n     = gain;
        jp_n       = jp;
        jm_n       = jm;
        gd_n       = gd;
        step_n     = step;
        meas_req_n = meas_req;
        done_n     = 1'b0;

        if (state != S_IDLE && bus.ABORT) begin
            state_n    = S_IDLE;
            u_out_n    = u;
            meas_req_n = 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (bus.LOAD) begin
                        u_n     = bus.U_INIT;
                        u_out_n = bus.U_INIT;
                    end else if (bus.START) begin
                        delta_n = bus.PERT;
                        gain_n  = bus.GAIN;
                        state_n = S_PLUS;
                    end
                end
                S_PLUS: begin
                    u_out_n    = sat_sum(u, delta, 1'b0);
                    meas_req_n = 1'b1;
                    state_n    = S_WAIT_P;
                end
                S_WAIT_P: begin
                    if (bus.METRIC_VALID && meas_req) begin
                        jp_n       = bus.METRIC;
                        meas_req_n = 1'b0;
                        state_n    = S_MINUS;
                    end
                end
                S_MINUS: begin
                    u_out_n    = sat_sum(u, delta, 1'b1);
                    meas_req_n = 1'b1;
                    state_n    = S_WAIT_M;
                end
                S_WAIT_M: begin
                    if (bus.METRIC_VALID && meas_req) begin
                        jm_n       = bus.METRIC;
                        meas_req_n = 1'b0;
                        state_n    = S_MUL_G;
                    end
                end
                S_MUL_G: begin
                    gd_n    = trim(prod_g);
                    state_n = S_MUL_P;
                end
                S_MUL_P: begin
                    step_n  = trim(prod_s);
                    state_n = S_UPD;
                end
                S_UPD: begin
                    u_n     = sat_sum(u, step, 1'b0);
                    u_out_n = u_n;
                    done_n  = 1'b1;
                    state_n = S_IDLE;
                end
                default: state_n = S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spgd_update.sv
// tb/tb_spgd_update.sv - randomized self-checking bench for spgd_update against an arithmetic model
module tb_spgd_update;
    typedef logic signed [63:0] fp_t;

    localparam fp_t ONE    = 64'sh0001_0000_0000_0000;
    localparam fp_t HALF   = 64'sh0000_8000_0000_0000;
    localparam fp_t FP_MAX = 64'sh7FFF_FFFF_FFFF_FFFF;
    localparam fp_t FP_MIN = 64'sh8000_0000_0000_0000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad = 0;

    spgd_update_if #(.FP_WIDTH(64)) bus ();

    spgd_update #(.FP_WIDTH(64), .INT_WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    fp_t model_u = '0;
    fp_t obs_plus, obs_minus, obs_final;
    int  obs_lat, obs_gap;
    bit  obs_busy, obs_hold, obs_timeout, obs_gap_low;

    // Reference arithmetic: wide integer math, then clamp to the format range.
    function automatic fp_t m_clamp(input logic signed [127:0] v);
        logic signed [127:0] hi, lo;
        hi = FP_MAX;
        lo = FP_MIN;
        if (v > hi) return FP_MAX;
        if (v < lo) return FP_MIN;
        return v[63:0];
    endfunction

    function automatic fp_t m_add(input fp_t a, input fp_t b, input bit sub);
        logic signed [127:0] s;
        s = a;
        s = sub ? s - b : s + b;
        return m_clamp(s);
    endfunction

    function automatic fp_t m_mul(input fp_t a, input fp_t b);
        logic signed [127:0] p;
        p = a;
        p = p * b;
        return m_clamp(p >>> 48);
    endfunction

    function automatic fp_t m_update(input fp_t u, input fp_t d, input fp_t g,
                                     input fp_t jp, input fp_t jm);
        return m_add(u, m_mul(m_mul(g, m_add(jp, jm, 1'b1)), d), 1'b0);
    endfunction

    function automatic fp_t rnd64();
        fp_t v;
        v = {$urandom, $urandom};
        return v;
    endfunction

    function automatic fp_t rnd_fp();
        fp_t v;
        v = rnd64();
        return v >>> $urandom_range(8, 40);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input fp_t v);
        bus.LOAD = 1'b1;
        bus.U_INIT = v;
        tick();
        bus.LOAD = 1'b0;
        bus.U_INIT = rnd64();
        model_u = v;
    endtask

    // Drives one full iteration and records what the DUT showed; checks live in the tests.
    task automatic run_iter(input fp_t d, input fp_t g, input fp_t jp, input fp_t jm,
                            input int dly, input bit stray);
        int n;
        obs_timeout = 0;
        bus.PERT = d;
        bus.GAIN = g;
        bus.START = 1'b1;
        tick();
        bus.START = 1'b0;
        bus.PERT = rnd64();
        bus.GAIN = rnd64();
        obs_busy = bus.BUSY;
        if (stray) begin
            bus.METRIC_VALID = 1'b1;
            bus.METRIC = rnd64();
        end
        obs_lat = 0;
        n = 0;
        do begin
            tick();
            obs_lat++;
            n++;
            bus.METRIC_VALID = 1'b0;
        end while (!bus.MEAS_REQ && n < 20);
        if (!bus.MEAS_REQ) obs_timeout = 1;
        obs_plus = bus.U_OUT;
        repeat (dly) begin
            tick();
            obs_lat++;
        end
        obs_hold = bus.MEAS_REQ && bus.BUSY && (bus.U_OUT === obs_plus);
        bus.METRIC = jp;
        bus.METRIC_VALID = 1'b1;
        tick();
        obs_lat++;
        obs_gap_low = !bus.MEAS_REQ;
        bus.METRIC_VALID = stray;
        bus.METRIC = rnd64();
        obs_gap = 0;
        n = 0;
        do begin
            tick();
            obs_lat++;
            obs_gap++;
            n++;
            bus.METRIC_VALID = 1'b0;
        end while (!bus.MEAS_REQ && n < 20);
        if (!bus.MEAS_REQ) obs_timeout = 1;
        obs_minus = bus.U_OUT;
        bus.METRIC = jm;
        bus.METRIC_VALID = 1'b1;
        tick();
        obs_lat++;
        bus.METRIC_VALID = 1'b0;
        n = 0;
        while (!bus.DONE && n < 20) begin
            tick();
            obs_lat++;
            n++;
        end
        if (!bus.DONE) obs_timeout = 1;
        obs_final = bus.U_OUT;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) tick();
        total++; if (bus.U_OUT !== 64'd0) begin bad++; $display("FAIL reset_u_out got=%h exp=0", bus.U_OUT); end
        total++; if (bus.MEAS_REQ !== 1'b0) begin bad++; $display("FAIL reset_meas_req got=%b exp=0", bus.MEAS_REQ); end
        total++; if (bus.BUSY !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.BUSY); end
        total++; if (bus.DONE !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", bus.DONE); end
        rst = 1'b1;
        tick();
        total++; if (bus.U_OUT !== 64'd0 || bus.BUSY !== 1'b0) begin bad++; $display("FAIL post_reset got=%h/%b exp=0/0", bus.U_OUT, bus.BUSY); end
        model_u = '0;
    endtask

    task automatic test_nominal();
        do_load('0);
        run_iter(HALF, 2 * ONE, 3 * ONE, ONE, 0, 0);
        total++; if (obs_busy !== 1'b1) begin bad++; $display("FAIL nom_busy got=%b exp=1", obs_busy); end
        total++; if (obs_plus !== HALF) begin bad++; $display("FAIL nom_plus got=%h exp=%h", obs_plus, HALF); end
        total++; if (obs_minus !== -HALF) begin bad++; $display("FAIL nom_minus got=%h exp=%h", obs_minus, -HALF); end
        total++; if (obs_final !== 2 * ONE) begin bad++; $display("FAIL nom_final got=%h exp=%h", obs_final, 2 * ONE); end
        total++; if (obs_lat !== 7 || obs_timeout) begin bad++; $display("FAIL nom_latency got=%0d exp=7", obs_lat); end
        model_u = 2 * ONE;
        tick();
        total++; if (bus.DONE !== 1'b0 || bus.U_OUT !== model_u) begin bad++; $display("FAIL nom_single_done got=%b/%h exp=0/%h", bus.DONE, bus.U_OUT, model_u); end
    endtask

    task automatic test_negative();
        do_load(ONE);
        run_iter(-(ONE >>> 2), ONE, HALF, ONE + HALF, 0, 0);
        total++; if (obs_final !== ONE + (ONE >>> 2)) begin bad++; $display("FAIL neg_final got=%h exp=%h", obs_final, ONE + (ONE >>> 2)); end
        model_u = obs_final;
    endtask

    task automatic test_saturation();
        fp_t exp_u;
        do_load(64'sh7FFF_0000_0000_0000);
        run_iter(ONE, ONE, ONE, ONE, 0, 0);
        total++; if (obs_plus !== FP_MAX) begin bad++; $display("FAIL sat_plus got=%h exp=%h", obs_plus, FP_MAX); end
        total++; if (obs_final !== 64'sh7FFF_0000_0000_0000) begin bad++; $display("FAIL sat_zero_step got=%h exp=7fff000000000000", obs_final); end
        do_load('0);
        run_iter(64'sh0000_0001_0000_0000, 64'sh7FFF_0000_0000_0000, 4 * ONE, '0, 0, 0);
        exp_u = m_update('0, 64'sh0000_0001_0000_0000, 64'sh7FFF_0000_0000_0000, 4 * ONE, '0);
        total++; if (obs_final !== 64'sh0000_7FFF_FFFF_FFFF) begin bad++; $display("FAIL sat_gd_clamp got=%h exp=00007fffffffffff", obs_final); end
        total++; if (obs_final !== exp_u) begin bad++; $display("FAIL sat_gd_model got=%h exp=%h", obs_final, exp_u); end
        model_u = obs_final;
    endtask

    task automatic test_handshake();
        fp_t d, g, jp, jm, exp_u;
        d = rnd_fp(); g = rnd_fp(); jp = rnd_fp(); jm = rnd_fp();
        exp_u = m_update(model_u, d, g, jp, jm);
        run_iter(d, g, jp, jm, 10, 1);
        total++; if (!obs_hold) begin bad++; $display("FAIL hs_hold got=0 exp=1"); end
        total++; if (!obs_gap_low || obs_gap !== 1) begin bad++; $display("FAIL hs_gap got=%0d exp=1", obs_gap); end
        total++; if (obs_lat !== 17 || obs_timeout) begin bad++; $display("FAIL hs_latency got=%0d exp=17", obs_lat); end
        total++; if (obs_final !== exp_u) begin bad++; $display("FAIL hs_final got=%h exp=%h", obs_final, exp_u); end
        model_u = exp_u;
    endtask

    task automatic test_abort();
        bit saw_done;
        do_load(3 * ONE);
        bus.PERT = HALF;
        bus.START = 1'b1;
        tick();
        bus.START = 1'b0;
        tick();
        bus.METRIC = ONE;
        bus.METRIC_VALID = 1'b1;
        tick();
        bus.METRIC_VALID = 1'b0;
        tick();
        total++; if (bus.MEAS_REQ !== 1'b1 || bus.U_OUT !== 3 * ONE - HALF) begin bad++; $display("FAIL abort_in_wait_m got=%b/%h exp=1/%h", bus.MEAS_REQ, bus.U_OUT, 3 * ONE - HALF); end
        bus.ABORT = 1'b1;
        bus.METRIC_VALID = 1'b1;
        bus.METRIC = rnd64();
        tick();
        bus.ABORT = 1'b0;
        bus.METRIC_VALID = 1'b0;
        total++; if (bus.BUSY !== 1'b0 || bus.MEAS_REQ !== 1'b0) begin bad++; $display("FAIL abort_idle got=%b/%b exp=0/0", bus.BUSY, bus.MEAS_REQ); end
        total++; if (bus.U_OUT !== model_u) begin bad++; $display("FAIL abort_u_out got=%h exp=%h", bus.U_OUT, model_u); end
        saw_done = bus.DONE;
        repeat (4) begin tick(); saw_done |= bus.DONE; end
        total++; if (saw_done !== 1'b0) begin bad++; $display("FAIL abort_no_done got=1 exp=0"); end
        bus.ABORT = 1'b1;
        bus.START = 1'b1;
        tick();
        bus.START = 1'b0;
        total++; if (bus.BUSY !== 1'b1) begin bad++; $display("FAIL abort_in_idle got=%b exp=1", bus.BUSY); end
        tick();
        bus.ABORT = 1'b0;
        total++; if (bus.BUSY !== 1'b0 || bus.U_OUT !== model_u) begin bad++; $display("FAIL abort_plus got=%b/%h exp=0/%h", bus.BUSY, bus.U_OUT, model_u); end
    endtask

    task automatic test_async_reset();
        do_load(5 * ONE);
        bus.PERT = ONE;
        bus.START = 1'b1;
        bus.METRIC = 2 * ONE;
        bus.METRIC_VALID = 1'b1;
        tick();
        bus.START = 1'b0;
        repeat (5) tick();
        total++; if (bus.BUSY !== 1'b1 || bus.U_OUT !== 4 * ONE) begin bad++; $display("FAIL arst_pre got=%b/%h exp=1/%h", bus.BUSY, bus.U_OUT, 4 * ONE); end
        #2 rst = 1'b0;
        #1;
        total++; if (bus.U_OUT !== 64'd0 || bus.BUSY !== 1'b0 || bus.MEAS_REQ !== 1'b0 || bus.DONE !== 1'b0) begin bad++; $display("FAIL arst_immediate got=%h/%b/%b/%b exp=0/0/0/0", bus.U_OUT, bus.BUSY, bus.MEAS_REQ, bus.DONE); end
        bus.METRIC_VALID = 1'b0;
        tick();
        rst = 1'b1;
        model_u = '0;
        repeat (3) tick();
        total++; if (bus.U_OUT !== 64'd0 || bus.DONE !== 1'b0) begin bad++; $display("FAIL arst_after got=%h/%b exp=0/0", bus.U_OUT, bus.DONE); end
    endtask

    task automatic test_load_priority();
        fp_t exp_u;
        bus.LOAD = 1'b1;
        bus.START = 1'b1;
        bus.U_INIT = 3 * ONE;
        bus.PERT = ONE;
        tick();
        bus.LOAD = 1'b0;
        bus.START = 1'b0;
        model_u = 3 * ONE;
        total++; if (bus.U_OUT !== 3 * ONE || bus.BUSY !== 1'b0) begin bad++; $display("FAIL ls_load got=%h/%b exp=%h/0", bus.U_OUT, bus.BUSY, 3 * ONE); end
        tick();
        total++; if (bus.BUSY !== 1'b0) begin bad++; $display("FAIL ls_start_ignored got=%b exp=0", bus.BUSY); end
        exp_u = m_update(model_u, HALF, ONE, 2 * ONE, ONE);
        run_iter(HALF, ONE, 2 * ONE, ONE, 0, 0);
        total++; if (obs_final !== exp_u) begin bad++; $display("FAIL ls_pert_latched got=%h exp=%h", obs_final, exp_u); end
        model_u = exp_u;
    endtask

    task automatic test_random();
        fp_t d, g, jp, jm;
        for (int i = 0; i < 12; i++) begin
            if ($urandom_range(0, 2) == 0) do_load(rnd_fp());
            d = rnd_fp(); g = rnd_fp(); jp = rnd_fp(); jm = rnd_fp();
            run_iter(d, g, jp, jm, $urandom_range(0, 3), $urandom_range(0, 1));
            total++; if (obs_plus !== m_add(model_u, d, 1'b0)) begin bad++; $display("FAIL rnd_plus[%0d] got=%h exp=%h", i, obs_plus, m_add(model_u, d, 1'b0)); end
            total++; if (obs_minus !== m_add(model_u, d, 1'b1)) begin bad++; $display("FAIL rnd_minus[%0d] got=%h exp=%h", i, obs_minus, m_add(model_u, d, 1'b1)); end
            model_u = m_update(model_u, d, g, jp, jm);
            total++; if (obs_final !== model_u || obs_timeout) begin bad++; $display("FAIL rnd_final[%0d] got=%h exp=%h", i, obs_final, model_u); end
        end
    endtask

    task automatic test_back_to_back();
        fp_t d;
        do_load(ONE);
        d = ONE >>> 3;
        run_iter(d, ONE, 2 * ONE, ONE, 0, 0);
        model_u = m_update(model_u, d, ONE, 2 * ONE, ONE);
        total++; if (obs_final !== model_u) begin bad++; $display("FAIL b2b_first got=%h exp=%h", obs_final, model_u); end
        run_iter(d, 2 * ONE, ONE, 3 * ONE, 0, 0);
        total++; if (obs_busy !== 1'b1 || obs_lat !== 7) begin bad++; $display("FAIL b2b_accept got=%b/%0d exp=1/7", obs_busy, obs_lat); end
        model_u = m_update(model_u, d, 2 * ONE, ONE, 3 * ONE);
        total++; if (obs_final !== model_u) begin bad++; $display("FAIL b2b_second got=%h exp=%h", obs_final, model_u); end
    endtask

    initial begin
        bus.START = 1'b0;
        bus.ABORT = 1'b0;
        bus.LOAD = 1'b0;
        bus.U_INIT = '0;
        bus.PERT = '0;
        bus.GAIN = '0;
        bus.METRIC = '0;
        bus.METRIC_VALID = 1'b0;
        test_reset();
        test_nominal();
        test_negative();
        test_saturation();
        test_handshake();
        test_abort();
        test_async_reset();
        test_load_priority();
        test_random();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
